mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares a single-ported unified memory between the fetch stage (read-only instruction requests) and the memory stage (load/store requests) of the 5-stage core. It sequences one memory transaction at a time through a req/ack handshake and returns the read data to the winning requester with a one-cycle valid pulse. The hazard unit uses `if_valid` and `d_valid` to build stallF/stallD/stallM. Data requests win by default. An anti-starvation counter guarantees fetch progress.

## Interface
- `ADDR_W`, 32: address width for all ports.
- `DATA_W`, 32: data width for all ports.
- `MAX_DSTREAK`, 4: maximum consecutive data grants issued while `if_req` is pending before fetch is forced to win. Legal range 1–15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; forces every register and output to its reset value immediately.
- `if_req` in 1: fetch request; held high with `if_addr` stable until `if_valid`.
- `if_addr` in ADDR_W: fetch address.
- `if_rdata` out DATA_W: fetched instruction; registered; reset 0.
- `if_valid` out 1: one-cycle pulse, `if_rdata` valid; reset 0.
- `d_req` in 1: data request; held high with `d_we`/`d_addr`/`d_wdata` stable until `d_valid`.
- `d_we` in 1: 1 means store, 0 means load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_rdata` out DATA_W: load data; registered; reset 0; updated only by loads.
- `d_valid` out 1: one-cycle pulse, access complete (load data valid or store committed); reset 0.
- `mem_req` out 1: memory request, registered; reset 0.
- `mem_we` out 1: memory write enable; reset 0.
- `mem_addr` out ADDR_W: memory address; reset 0.
- `mem_wdata` out DATA_W: memory write data; reset 0.
- `mem_ack` in 1: memory completes the current access in this cycle; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in DATA_W: memory read data.

## Operation
- FSM states are IDLE, IBUSY, DBUSY and RESP. Reset state is IDLE.
- **IDLE, no requests:** stay in IDLE.
- **IDLE, grant decision:** if any request is high, pick a winner:
  - Data wins if `d_req` is high and (`if_req` is low or `dstreak` < `MAX_DSTREAK`).
  - Otherwise fetch wins.
- **IDLE, on grant:** register the winner's address, we and wdata into the `mem_*` outputs, set `mem_req`=1, and go to DBUSY or IBUSY.
  - Fetch sets `mem_we`=0 and `mem_wdata`=0.
- **IBUSY / DBUSY:**
  - Hold `mem_req` and all `mem_*` fields stable until `mem_ack`.
  - On `mem_ack`: clear `mem_req`, go to RESP, and raise the matching valid in RESP.
  - On a load or fetch, capture `mem_rdata` into `d_rdata` or `if_rdata` on the ack edge.
  - `mem_ack` seen in IDLE or RESP is ignored.
- **RESP:** exactly one of `if_valid`/`d_valid` is 1; all request inputs are ignored; next state is IDLE.
  - A requester deasserts `req` or presents a new request at the end of the RESP cycle.
  - Any `req` high in the following IDLE cycle is treated as a new request.
- **`dstreak` counter (4-bit):**
  - Data grant with `if_req`=1: increment, saturating at `MAX_DSTREAK`.
  - Data grant with `if_req`=0: clear to 0.
  - Fetch grant: clear to 0.
  - Reset: 0.
- **Reset mid-transaction:** return to IDLE, drop `mem_req` immediately, zero all outputs and discard the outstanding access. Memory shares `reset`. Requesters reissue after reset.
- `if_rdata` holds its value between fetches. `d_rdata` holds its value across stores.

## Timing
- A request sampled high in the IDLE cycle at edge N gives `mem_req`=1 in cycle N+1.
- A `mem_ack` in cycle N+1+k (k ≥ 0 wait cycles) gives the valid pulse in cycle N+2+k.
- FSM is back in IDLE in cycle N+3+k.
- Minimum service time with a zero-wait memory is 3 cycles per access. At most one access is in flight.
- `mem_*` outputs are registered and change only on the grant edge or ack edge.
- Valid outputs are registered and last exactly 1 cycle.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless `dstreak` = `MAX_DSTREAK`.
- The losing request stays pending and is re-arbitrated in the next IDLE cycle.

## Test plan
- **Single fetch, zero-wait memory:** `if_req`=1, `if_addr`=0x40 at cycle 0, `mem_ack`=1 the cycle `mem_req` rises with `mem_rdata`=0x8C020004. Expect `mem_req` in cycle 1 with `mem_addr`=0x40, `mem_we`=0; `if_valid` in cycle 2 with `if_rdata`=0x8C020004; IDLE in cycle 3.
- **Store then load, 2 wait cycles:**
  - Store `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_we`=1. Expect `mem_we`=1 and fields stable for 3 cycles, then `d_valid` with `d_rdata` unchanged (0).
  - Then load 0x100 with `mem_rdata`=0xDEADBEEF. Expect `d_rdata`=0xDEADBEEF.
- **Simultaneous requests, `MAX_DSTREAK`=4:** hold `if_req` and `d_req` high continuously, reissuing `d_req` after each `d_valid`. Expect grant order D, D, D, D, I, D…; `dstreak` is 4 before the fetch grant and 0 after.
- **Data grant with no pending fetch:** issue three data requests with `if_req`=0, then raise both. Expect data wins (`dstreak` was 0).
- **Reset mid-access:** assert `reset` in DBUSY while `mem_req`=1. Expect all outputs 0 the same cycle with no `d_valid`; after release, a reissued `d_req` completes normally.
- **Stray ack:** pulse `mem_ack` in IDLE and in RESP. Expect no state change, no valid pulse and no data update.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between fetch and data requesters, data-priority with a fetch anti-starvation streak limit.
// Latency: grant -> mem_req next cycle, valid pulse one cycle after mem_ack, IDLE one cycle later; requesters hold req until valid.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] DSTREAK_MAX = 4'(MAX_DSTREAK);

    state_t     state;
    logic [3:0] dstreak;
    logic       data_wins;

    // Data keeps priority until it has won DSTREAK_MAX times in a row over a waiting fetch.
    assign data_wins = d_req && (!if_req || (dstreak < DSTREAK_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dstreak   <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_wins) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        if (!if_req)
                            dstreak <= 4'd0;
                        else if (dstreak < DSTREAK_MAX)
                            dstreak <= dstreak + 4'd1;
                        state <= DBUSY;
                    end else if (if_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        dstreak   <= 4'd0;
                        state     <= IBUSY;
                    end
                end
                IBUSY: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        if_rdata <= mem_rdata;
                        if_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                DBUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                        d_valid <= 1'b1;
                        state   <= RESP;
                    end
                end
                // Requests and acks are ignored here so requesters can drop or renew req.
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store/load with waits, grant fairness, reset abort, stray acks.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] I_ADDR = 32'h0000_0200;
    localparam logic [31:0] D_ADDR = 32'h0000_0300;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h ivld=%b irdata=%h dvld=%b drdata=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata);
        end
        reset = 1'b0;
        tick();
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: mem_req got %b want 0", mem_req);
        end
    endtask

    task automatic test_single_fetch();
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        total++;
        if ({mem_req, mem_we, mem_addr, if_valid} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
            bad++;
            $display("FAIL fetch_grant: got req=%b we=%b addr=%h ivld=%b want 1 0 00000040 0",
                     mem_req, mem_we, mem_addr, if_valid);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h8C02_0004;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({if_valid, if_rdata, mem_req, d_valid} !== {1'b1, 32'h8C02_0004, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL fetch_resp: got ivld=%b irdata=%h req=%b dvld=%b want 1 8c020004 0 0",
                     if_valid, if_rdata, mem_req, d_valid);
        end
        if_req = 1'b0;
        tick();
        total++;
        if ({if_valid, mem_req, if_rdata} !== {1'b0, 1'b0, 32'h8C02_0004}) begin
            bad++;
            $display("FAIL fetch_idle: got ivld=%b req=%b irdata=%h want 0 0 8c020004", if_valid, mem_req, if_rdata);
        end
    endtask

    task automatic test_store_load();
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h100;
        d_wdata   = 32'hDEAD_BEEF;
        mem_rdata = 32'h5555_5555;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, d_valid} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
                bad++;
                $display("FAIL store_hold[%0d]: got req=%b we=%b addr=%h wdata=%h dvld=%b want 1 1 00000100 deadbeef 0",
                         c, mem_req, mem_we, mem_addr, mem_wdata, d_valid);
            end
            if (c == 2) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
        total++;
        if ({d_valid, d_rdata, mem_req} !== {1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL store_resp: got dvld=%b drdata=%h req=%b want 1 00000000 0", d_valid, d_rdata, mem_req);
        end
        d_req = 1'b0;
        tick();
        d_we    = 1'b0;
        d_wdata = '0;
        d_req   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({mem_req, mem_we, mem_addr, d_valid} !== {1'b1, 1'b0, 32'h100, 1'b0}) begin
                bad++;
                $display("FAIL load_hold[%0d]: got req=%b we=%b addr=%h dvld=%b want 1 0 00000100 0",
                         c, mem_req, mem_we, mem_addr, d_valid);
            end
            if (c == 2) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h5555_5555;
        total++;
        if ({d_valid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL load_resp: got dvld=%b drdata=%h want 1 deadbeef", d_valid, d_rdata);
        end
        d_req = 1'b0;
        tick();
        total++;
        if ({d_valid, d_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL load_idle: got dvld=%b drdata=%h want 0 deadbeef", d_valid, d_rdata);
        end
    endtask

    task automatic test_streak();
        string exp_order = "DDDDIDDD";
        if_addr = I_ADDR;
        d_addr  = D_ADDR;
        d_we    = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (mem_addr !== ((exp_order[i] == "D") ? D_ADDR : I_ADDR) || mem_req !== 1'b1) begin
                bad++;
                $display("FAIL streak_grant[%0d]: got req=%b addr=%h want grant %s", i, mem_req, mem_addr,
                         (exp_order[i] == "D") ? "data" : "fetch");
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'h1000 + i;
            tick();
            mem_ack = 1'b0;
            total++;
            if ({d_valid, if_valid} !== ((exp_order[i] == "D") ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL streak_valid[%0d]: got dvld=%b ivld=%b", i, d_valid, if_valid);
            end
            tick();
        end
    endtask

    task automatic test_no_pending_fetch();
        string exp_order = "DDDDDDDI";
        d_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if_req = (i >= 3);
            tick();
            total++;
            if (mem_addr !== ((exp_order[i] == "D") ? D_ADDR : I_ADDR) || mem_req !== 1'b1) begin
                bad++;
                $display("FAIL nofetch_grant[%0d]: got req=%b addr=%h want grant %s", i, mem_req, mem_addr,
                         (exp_order[i] == "D") ? "data" : "fetch");
            end
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset_mid_access();
        if_req  = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h104;
        d_wdata = 32'hCAFE_0001;
        tick();
        total++;
        if ({mem_req, mem_we} !== 2'b11) begin
            bad++;
            $display("FAIL abort_busy: got req=%b we=%b want 1 1", mem_req, mem_we);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata} !== '0) begin
            bad++;
            $display("FAIL abort_async: got req=%b we=%b addr=%h wdata=%h ivld=%b irdata=%h dvld=%b drdata=%h want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata, d_valid, d_rdata);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, d_valid, if_valid} !== 3'b000) begin
            bad++;
            $display("FAIL abort_held: got req=%b dvld=%b ivld=%b want 0 0 0", mem_req, d_valid, if_valid);
        end
        reset     = 1'b0;
        d_we      = 1'b0;
        mem_rdata = 32'h1234_5678;
        tick();
        total++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h104}) begin
            bad++;
            $display("FAIL reissue_grant: got req=%b we=%b addr=%h want 1 0 00000104", mem_req, mem_we, mem_addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({d_valid, d_rdata} !== {1'b1, 32'h1234_5678}) begin
            bad++;
            $display("FAIL reissue_resp: got dvld=%b drdata=%h want 1 12345678", d_valid, d_rdata);
        end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        tick();
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, if_valid, d_valid, d_rdata, if_rdata} !== {3'b000, 32'h1234_5678, 32'h0}) begin
            bad++;
            $display("FAIL stray_idle: got req=%b ivld=%b dvld=%b drdata=%h irdata=%h want 0 0 0 12345678 00000000",
                     mem_req, if_valid, d_valid, d_rdata, if_rdata);
        end
        if_req  = 1'b1;
        if_addr = 32'h44;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hAAAA_0001;
        tick();
        total++;
        if ({if_valid, if_rdata} !== {1'b1, 32'hAAAA_0001}) begin
            bad++;
            $display("FAIL stray_fetch: got ivld=%b irdata=%h want 1 aaaa0001", if_valid, if_rdata);
        end
        if_req    = 1'b0;
        mem_rdata = 32'hBBBB_0002;
        tick();
        mem_ack = 1'b0;
        total++;
        if ({mem_req, if_valid, d_valid, if_rdata, d_rdata} !== {3'b000, 32'hAAAA_0001, 32'h1234_5678}) begin
            bad++;
            $display("FAIL stray_resp: got req=%b ivld=%b dvld=%b irdata=%h drdata=%h want 0 0 0 aaaa0001 12345678",
                     mem_req, if_valid, d_valid, if_rdata, d_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_load();
        test_streak();
        test_no_pending_fetch();
        test_reset_mid_access();
        test_stray_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
